// File: rtl/tag_fifo_if.sv
// rtl/tag_fifo_if.sv - dispatch/commit handshake bundle for the tag free-list
interface tag_fifo_if #(
    parameter int TAG_W = 5
);
    logic             alloc_req;
    logic [TAG_W-1:0] alloc_tag;
    logic             empty;
    logic             free_req;
    logic [TAG_W-1:0] free_tag;
    logic             full;
    logic [TAG_W:0]   count;
    logic             err;

    modport master (
        output alloc_req,
        output free_req,
        output free_tag,
        input  alloc_tag,
        input  empty,
        input  full,
        input  count,
        input  err
    );

    modport slave (
        input  alloc_req,
        input  free_req,
        input  free_tag,
        output alloc_tag,
        output empty,
        output full,
        output count,
        output err
    );
endinterface

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - free-list of rd tags, preloaded with every tag; optional TAG_FIFO_BYPASS_EN
module tag_fifo #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    tag_fifo_if.slave  bus
);
    localparam int PW = TAG_W + 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [TAG_W-1:0] rd_idx;
    logic [TAG_W-1:0] wr_idx;
    logic             empty_c;
    logic             full_c;
    logic             bypass;
    logic             bypass_take;
    logic             do_pop;
    logic             do_push;
    logic             bad_pop;
    logic             bad_push;
    logic             err_q;

    assign rd_idx = rd_ptr[TAG_W-1:0];
    assign wr_idx = wr_ptr[TAG_W-1:0];

    // Status is derived from the registered pointers only.
    always_comb begin
        empty_c = (rd_ptr == wr_ptr);
        full_c  = (rd_idx == wr_idx) && (rd_ptr[TAG_W] != wr_ptr[TAG_W]);
    end

`ifdef TAG_FIFO_BYPASS_EN
    // A tag returned while the list is empty can be handed straight to dispatch.
    assign bypass = empty_c & bus.free_req;
`else
    assign bypass = 1'b0;
`endif

    // Request qualification; full is judged on current state, so a pop never opens room for a same-cycle push.
    always_comb begin
        bypass_take = bypass & bus.alloc_req;
        do_pop      = bus.alloc_req & ~empty_c;
        do_push     = bus.free_req & ~full_c & ~bypass_take;
        bad_pop     = bus.alloc_req & empty_c & ~bypass;
        bad_push    = bus.free_req & full_c;
    end

    // Storage and pointers; reset reloads every tag in order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_W'(i);
            end
            rd_ptr <= '0;
            wr_ptr <= {1'b1, {TAG_W{1'b0}}};
        end else begin
            if (do_push) begin
                mem[wr_idx] <= bus.free_tag;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Sticky error flag for any rejected request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (bad_pop || bad_push) begin
            err_q <= 1'b1;
        end
    end

    assign bus.alloc_tag = bypass ? bus.free_tag : mem[rd_idx];
    assign bus.empty     = empty_c;
    assign bus.full      = full_c;
    assign bus.count     = wr_ptr - rd_ptr;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_tag_fifo.sv
// tb/tb_tag_fifo.sv - directed self-checking bench for tag_fifo
module tb_tag_fifo;
    localparam int TAG_W = 5;
    localparam int DEPTH = 32;

    logic clock;
    logic reset_n;
    int   total;
    int   passed;
    int   q[$];
    int   tags3[3];

    tag_fifo_if #(.TAG_W(TAG_W)) bus ();

    tag_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        total         = 0;
        passed        = 0;
        tags3         = '{7, 3, 12};
        reset_n       = 1'b0;
        bus.alloc_req = 1'b0;
        bus.free_req  = 1'b0;
        bus.free_tag  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;

        // reset state
        check("rst_count", 32'(bus.count), 32);
        check("rst_full", 32'(bus.full), 1);
        check("rst_empty", 32'(bus.empty), 0);
        check("rst_tag", 32'(bus.alloc_tag), 0);
        check("rst_err", 32'(bus.err), 0);

        // drain all 32 tags in order
        bus.alloc_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("pop_seq", 32'(bus.alloc_tag), 32'(i));
            tick();
        end
        bus.alloc_req = 1'b0;
        #1;
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_count", 32'(bus.count), 0);
        check("drain_err", 32'(bus.err), 0);

        // free 7,3,12 then pop them back
        for (int i = 0; i < 3; i++) begin
            bus.free_req = 1'b1;
            bus.free_tag = TAG_W'(tags3[i]);
            tick();
        end
        bus.free_req = 1'b0;
        check("free3_count", 32'(bus.count), 3);
        bus.alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("free3_tag", 32'(bus.alloc_tag), 32'(tags3[i]));
            check("free3_cnt", 32'(bus.count), 32'(3 - i));
            tick();
        end
        bus.alloc_req = 1'b0;
        check("free3_end", 32'(bus.count), 0);

        // simultaneous push+pop at count 5, recirculating tags across the wrap
        for (int i = 0; i < 5; i++) begin
            bus.free_req = 1'b1;
            bus.free_tag = TAG_W'(20 + i);
            q.push_back(20 + i);
            tick();
        end
        check("pp_start", 32'(bus.count), 5);
        for (int c = 0; c < 40; c++) begin
            bus.alloc_req = 1'b1;
            bus.free_req  = 1'b1;
            bus.free_tag  = TAG_W'(q[0]);
            check("pp_tag", 32'(bus.alloc_tag), 32'(q[0]));
            tick();
            q.push_back(q.pop_front());
            check("pp_count", 32'(bus.count), 5);
        end
        bus.free_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("pp_drain", 32'(bus.alloc_tag), 32'(q[0]));
            void'(q.pop_front());
            tick();
        end
        bus.alloc_req = 1'b0;
        check("pp_empty", 32'(bus.empty), 1);

`ifdef TAG_FIFO_BYPASS_EN
        // bypass: returned tag goes straight to dispatch
        bus.free_req  = 1'b1;
        bus.free_tag  = TAG_W'(9);
        bus.alloc_req = 1'b1;
        #1;
        check("byp_tag", 32'(bus.alloc_tag), 9);
        tick();
        bus.free_req  = 1'b0;
        bus.alloc_req = 1'b0;
        check("byp_err", 32'(bus.err), 0);
        check("byp_count", 32'(bus.count), 0);
        check("byp_empty", 32'(bus.empty), 1);
`endif

        // illegal pop while empty
        bus.alloc_req = 1'b1;
        tick();
        bus.alloc_req = 1'b0;
        check("epop_err", 32'(bus.err), 1);
        check("epop_count", 32'(bus.count), 0);
        check("epop_empty", 32'(bus.empty), 1);
        bus.free_req = 1'b1;
        bus.free_tag = TAG_W'(9);
        tick();
        bus.free_req = 1'b0;
        check("epop_ptr", 32'(bus.alloc_tag), 9);
        check("epop_cnt1", 32'(bus.count), 1);
        check("err_sticky", 32'(bus.err), 1);

        // reset, then illegal push while full
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        check("rst2_full", 32'(bus.full), 1);
        check("rst2_err", 32'(bus.err), 0);
        bus.free_req = 1'b1;
        bus.free_tag = TAG_W'(5);
        tick();
        bus.free_req = 1'b0;
        check("fpush_err", 32'(bus.err), 1);
        check("fpush_count", 32'(bus.count), 32);
        check("fpush_tag", 32'(bus.alloc_tag), 0);

        // pop 22 to reach count 10, then async reset mid-cycle
        bus.alloc_req = 1'b1;
        for (int i = 0; i < 22; i++) tick();
        bus.alloc_req = 1'b0;
        check("mid_count", 32'(bus.count), 10);
        check("mid_tag", 32'(bus.alloc_tag), 22);
        reset_n = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 32);
        check("arst_tag", 32'(bus.alloc_tag), 0);
        check("arst_err", 32'(bus.err), 0);
        check("arst_full", 32'(bus.full), 1);
        #1;
        reset_n = 1'b1;
        tick();
        check("post_count", 32'(bus.count), 32);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
